// File: rtl/rf_wport_arbiter.sv
// rtl/rf_wport_arbiter.sv - register-file write-port arbiter between WB and a buffered aux unit
// WB wins the port by default; aux results wait in a small FIFO and are forced through on starvation.
module rf_wport_arbiter #(
  parameter int AUX_DEPTH  = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic        wb_we,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_wdata,
  input  logic [31:0] wb_pc,
  output logic        wb_ready,
  input  logic        aux_valid,
  input  logic [4:0]  aux_dest,
  input  logic [31:0] aux_wdata,
  input  logic [31:0] aux_pc,
  output logic        aux_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pend_mask,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam int AW = $clog2(AUX_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SW-1:0]  starve_cnt_q, starve_cnt_d;
  logic [4:0]     dest_q [AUX_DEPTH];
  logic [4:0]     dest_d [AUX_DEPTH];
  logic [31:0]    data_q [AUX_DEPTH];
  logic [31:0]    data_d [AUX_DEPTH];
  logic [31:0]    pc_q   [AUX_DEPTH];
  logic [31:0]    pc_d   [AUX_DEPTH];

  logic [AW-1:0]  wr_idx, rd_idx, off;
  logic [AW:0]    occ;
  logic           empty, full, wb_busy, force_aux, grant_aux, push, pop;
  logic [4:0]     head_dest;
  logic [31:0]    head_data, head_pc;

  always_comb begin
    wr_idx    = wr_ptr_q[AW-1:0];
    rd_idx    = rd_ptr_q[AW-1:0];
    occ       = wr_ptr_q - rd_ptr_q;
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    head_dest = dest_q[rd_idx];
    head_data = data_q[rd_idx];
    head_pc   = pc_q[rd_idx];

    wb_busy   = wb_valid & wb_we;
    force_aux = !empty && (starve_cnt_q == SW'(STARVE_MAX));
    grant_aux = !empty && (!wb_busy || force_aux);
    push      = aux_valid & !full;
    pop       = grant_aux;

    aux_ready = !full;
    wb_ready  = !(force_aux & wb_busy);

    if (grant_aux) begin
      rf_we       = (head_dest != 5'd0);
      rf_waddr    = head_dest;
      rf_wdata    = head_data;
      debug_wb_pc = head_pc;
    end else begin
      rf_we       = wb_busy && (wb_dest != 5'd0);
      rf_waddr    = wb_dest;
      rf_wdata    = wb_wdata;
      debug_wb_pc = wb_pc;
    end
    debug_wb_rf_we    = {4{rf_we}};
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;

    // An entry is live when its distance from the read index is below the occupancy.
    pend_mask = 32'd0;
    off       = '0;
    for (int i = 0; i < AUX_DEPTH; i++) begin
      off = AW'(i) - rd_idx;
      if ({1'b0, off} < occ) pend_mask[dest_q[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;

    dest_d = dest_q;
    data_d = data_q;
    pc_d   = pc_q;
    if (push) begin
      dest_d[wr_idx] = aux_dest;
      data_d[wr_idx] = aux_wdata;
      pc_d[wr_idx]   = aux_pc;
    end
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

    if (empty || grant_aux) starve_cnt_d = '0;
    else                    starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      starve_cnt_q <= '0;
      for (int i = 0; i < AUX_DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      dest_q       <= dest_d;
      data_q       <= data_d;
      pc_q         <= pc_d;
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb/tb_rf_wport_arbiter.sv - directed and randomized checks of rf_wport_arbiter against a queue model
module tb_rf_wport_arbiter;
  localparam int DEPTH = 2;
  localparam int SMAX  = 3;

  logic clk = 1'b0;
  logic resetn;
  logic wb_valid, wb_we, aux_valid;
  logic [4:0]  wb_dest, aux_dest;
  logic [31:0] wb_wdata, wb_pc, aux_wdata, aux_pc;
  logic wb_ready, aux_ready, rf_we;
  logic [4:0]  rf_waddr, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, pend_mask, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_we;

  rf_wport_arbiter #(.AUX_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .resetn(resetn),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest), .wb_wdata(wb_wdata), .wb_pc(wb_pc),
    .wb_ready(wb_ready),
    .aux_valid(aux_valid), .aux_dest(aux_dest), .aux_wdata(aux_wdata), .aux_pc(aux_pc),
    .aux_ready(aux_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pend_mask(pend_mask),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   starve;
  int   tests = 0;
  int   fails = 0;
  bit   m_gaux;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    bit busy, emp, forced, gaux, we;
    logic [4:0] a;
    logic [31:0] d, pc, pm;
    busy   = wb_valid && wb_we;
    emp    = (q.size() == 0);
    forced = !emp && (starve == SMAX);
    gaux   = !emp && (!busy || forced);
    m_gaux = gaux;
    if (gaux) begin
      a = q[0].dest; d = q[0].data; pc = q[0].pc; we = (a != 0);
    end else begin
      a = wb_dest; d = wb_wdata; pc = wb_pc; we = busy && (a != 0);
    end
    pm = 32'd0;
    foreach (q[k]) pm = pm | (32'd1 << q[k].dest);
    pm = pm & ~32'd1;
    chk("rf_we", {31'd0, rf_we}, {31'd0, we});
    chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, a});
    chk("rf_wdata", rf_wdata, d);
    chk("wb_ready", {31'd0, wb_ready}, {31'd0, !(forced && busy)});
    chk("aux_ready", {31'd0, aux_ready}, {31'd0, q.size() < DEPTH});
    chk("pend_mask", pend_mask, pm);
    chk("debug_we", {28'd0, debug_wb_rf_we}, {28'd0, {4{we}}});
    if (!(gaux && !we)) begin
      chk("debug_pc", debug_wb_pc, pc);
      chk("debug_wnum", {27'd0, debug_wb_rf_wnum}, {27'd0, a});
      chk("debug_wdata", debug_wb_rf_wdata, d);
    end
  endtask

  task automatic model_update();
    bit was_full, was_empty;
    if (!resetn) begin
      q.delete();
      starve = 0;
      return;
    end
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (m_gaux) void'(q.pop_front());
    if (aux_valid && !was_full) q.push_back('{aux_dest, aux_wdata, aux_pc});
    starve = (was_empty || m_gaux) ? 0 : starve + 1;
  endtask

  // Called with clk low and inputs already driven.
  task automatic tick();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_we = 0; wb_dest = 0; wb_wdata = 0; wb_pc = 0;
    aux_valid = 0; aux_dest = 0; aux_wdata = 0; aux_pc = 0;
  endtask

  task automatic wb_write(input logic [4:0] dst, input logic [31:0] dat);
    wb_valid = 1; wb_we = 1; wb_dest = dst; wb_wdata = dat; wb_pc = 32'h1000 + {27'd0, dst};
  endtask

  task automatic aux_push(input logic [4:0] dst, input logic [31:0] dat);
    aux_valid = 1; aux_dest = dst; aux_wdata = dat; aux_pc = 32'h2000 + {27'd0, dst};
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    resetn = 0;
    q.delete();
    starve = 0;
    tick();
    resetn = 1;
  endtask

  initial begin
    int d;
    resetn = 0;
    idle_inputs();
    starve = 0;
    m_gaux = 0;
    do_reset();

    // Reset state then a plain WB write.
    #1;
    chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset_aux_ready", {31'd0, aux_ready}, 32'd1);
    chk("reset_pend", pend_mask, 32'd0);
    chk("reset_dbg_pc", debug_wb_pc, 32'd0);
    wb_valid = 1; wb_we = 1; wb_dest = 5; wb_wdata = 32'h1234; wb_pc = 32'h100;
    #1;
    chk("t1_rf_we", {31'd0, rf_we}, 32'd1);
    chk("t1_waddr", {27'd0, rf_waddr}, 32'd5);
    chk("t1_wdata", rf_wdata, 32'h1234);
    chk("t1_wb_ready", {31'd0, wb_ready}, 32'd1);
    chk("t1_dbg_we", {28'd0, debug_wb_rf_we}, 32'hF);
    tick();

    // Aux push with WB idle: one cycle of latency, pend visible for that cycle only.
    idle_inputs();
    aux_push(7, 32'hDEAD);
    #1;
    chk("t2_pend_before", pend_mask, 32'd0);
    tick();
    idle_inputs();
    #1;
    chk("t2_rf_we", {31'd0, rf_we}, 32'd1);
    chk("t2_waddr", {27'd0, rf_waddr}, 32'd7);
    chk("t2_wdata", rf_wdata, 32'hDEAD);
    chk("t2_pend", pend_mask, 32'h80);
    tick();
    #1;
    chk("t2_pend_after", pend_mask, 32'd0);
    tick();

    // Starvation: WB writes every cycle; aux forced on the 4th visible cycle.
    wb_write(1, 32'h11);
    aux_push(9, 32'h99);
    tick();
    aux_valid = 0;
    d = 10;
    for (int k = 0; k < 5; k++) begin
      wb_write(d[4:0], 32'h500 + d);
      #1;
      if (k == 3) begin
        chk("t3_waddr_forced", {27'd0, rf_waddr}, 32'd9);
        chk("t3_ready_forced", {31'd0, wb_ready}, 32'd0);
      end else begin
        chk("t3_waddr_wb", {27'd0, rf_waddr}, d);
        chk("t3_ready_wb", {31'd0, wb_ready}, 32'd1);
        d++;
      end
      tick();
    end

    // Fill the FIFO while WB writes, hold off a third push, then drain in order.
    wb_write(20, 32'h20);
    aux_push(3, 32'h33);
    tick();
    wb_write(21, 32'h21);
    aux_push(4, 32'h44);
    #1;
    chk("t4_ready_one", {31'd0, aux_ready}, 32'd1);
    tick();
    wb_write(22, 32'h22);
    aux_push(6, 32'h66);
    #1;
    chk("t4_ready_full", {31'd0, aux_ready}, 32'd0);
    chk("t4_pend_full", pend_mask, 32'h18);
    tick();
    idle_inputs();
    #1;
    chk("t4_drain0", {27'd0, rf_waddr}, 32'd3);
    tick();
    #1;
    chk("t4_drain1", {27'd0, rf_waddr}, 32'd4);
    chk("t4_pend1", pend_mask, 32'h10);
    tick();
    #1;
    chk("t4_empty_pend", pend_mask, 32'd0);
    tick();

    // Non-writing WB retires alongside an aux grant; dest-0 entry pops silently.
    wb_write(23, 32'h23);
    aux_push(0, 32'h55);
    tick();
    wb_write(24, 32'h24);
    aux_push(11, 32'hBB);
    tick();
    idle_inputs();
    wb_valid = 1; wb_we = 0; wb_dest = 25;
    #1;
    chk("t5_r0_we", {31'd0, rf_we}, 32'd0);
    chk("t5_ready", {31'd0, wb_ready}, 32'd1);
    chk("t5_pend", pend_mask, 32'h800);
    tick();
    #1;
    chk("t5_aux_we", {31'd0, rf_we}, 32'd1);
    chk("t5_aux_addr", {27'd0, rf_waddr}, 32'd11);
    chk("t5_ready2", {31'd0, wb_ready}, 32'd1);
    tick();

    // Reset with two entries pending discards them.
    wb_write(26, 32'h26);
    aux_push(12, 32'hC);
    tick();
    aux_push(13, 32'hD);
    tick();
    aux_valid = 0;
    #1;
    chk("t6_pend_before", pend_mask, 32'h3000);
    idle_inputs();
    resetn = 0;
    q.delete();
    starve = 0;
    #1;
    chk("t6_ready_rst", {31'd0, aux_ready}, 32'd1);
    chk("t6_pend_rst", pend_mask, 32'd0);
    tick();
    resetn = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t6_no_write", {31'd0, rf_we}, 32'd0);
      tick();
    end

    // Randomized traffic, with the occasional reset.
    for (int n = 0; n < 3000; n++) begin
      resetn    = ($urandom_range(0, 199) != 0);
      wb_valid  = ($urandom_range(0, 3) != 0);
      wb_we     = ($urandom_range(0, 3) != 0);
      wb_dest   = 5'($urandom_range(0, 31));
      wb_wdata  = $urandom;
      wb_pc     = $urandom;
      aux_valid = ($urandom_range(0, 2) == 0);
      aux_dest  = 5'($urandom_range(0, 31));
      aux_wdata = $urandom;
      aux_pc    = $urandom;
      if (!resetn) begin
        q.delete();
        starve = 0;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
